// File: rtl/cyclic_lane_encoder_if.sv
// ---------------------------------------------------------------------------
// cyclic_lane_encoder_if
//   Handshake/data bundle between a message source, the cyclic lane encoder
//   and the downstream codeword sink.
//
//   in_valid   : message word valid                 (source -> encoder)
//   in_ready   : encoder accepts the word this cycle (encoder -> source)
//   data_in    : 32-bit message word                 (source -> encoder)
//   out_valid  : data_out holds a codeword word      (encoder -> sink)
//   out_ready  : sink accepts the word               (sink -> encoder)
//   data_out   : 32-bit codeword word                (encoder -> sink)
//   out_parity : current output word is parity       (encoder -> sink)
//   out_last   : current output word ends codeword   (encoder -> sink)
//
//   master : the environment side (drives message input and out_ready)
//   slave  : the encoder side
// ---------------------------------------------------------------------------
interface cyclic_lane_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        out_parity;
  logic        out_last;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_parity, out_last
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, out_parity, out_last
  );
endinterface

// File: rtl/cyclic_lane_encoder.sv
// ---------------------------------------------------------------------------
// cyclic_lane_encoder
//   Transmit-side systematic cyclic encoder for the bit-serial lane code path.
//   Every bit lane of the data word carries one message bit per word. After K
//   message words pass through unchanged, D = N-K parity words follow; each
//   parity bit is that lane's remainder of m(x)*x^D mod g(x), emitted highest
//   degree first. The first message word is the x^(K-1) coefficient.
//
// Parameters
//   N : codeword length in words
//   K : message length in words (D = N-K must be >= 2)
//   G : low D coefficients of g(x); the x^D term is implicit
//   W : number of active lanes (data bits [W-1:0])
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous, active-high reset
//   bus      : cyclic_lane_encoder_if.slave handshake/data bundle
//   cw_count : (only with CYCENC_CW_COUNT_EN defined) count of codewords
//              whose final word has been handed off, wraps at 16 bits
//
// Optional feature macro: CYCENC_CW_COUNT_EN
// ---------------------------------------------------------------------------
module cyclic_lane_encoder #(
  parameter int unsigned      N = 5,
  parameter int unsigned      K = 3,
  parameter logic [N-K-1:0]   G = 2'b11,
  parameter int unsigned      W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cyclic_lane_encoder_if.slave  bus
`ifdef CYCENC_CW_COUNT_EN
  ,
  output logic [15:0]           cw_count
`endif
);

  localparam int unsigned D  = N - K;
  localparam int unsigned MW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW = $clog2(D);

  localparam logic [MW-1:0] MSG_LAST = MW'(K - 1);
  localparam logic [PW-1:0] PAR_LAST = PW'(D - 1);

  typedef enum logic {
    ST_MSG,
    ST_PAR
  } state_t;

  state_t              state_q,     state_d;
  logic [MW-1:0]       msg_cnt_q,   msg_cnt_d;
  logic [PW-1:0]       par_cnt_q,   par_cnt_d;
  logic [W-1:0][D-1:0] lfsr_q,      lfsr_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         data_q,      data_d;
  logic                parity_q,    parity_d;
  logic                last_q,      last_d;

  logic slot_free;
  logic in_ready;
  logic accept;

  // The output register may be refilled when empty or when its word is
  // being taken this very cycle.
  assign slot_free = !out_valid_q || bus.out_ready;
  // Held low during reset so no word is offered acceptance while the
  // block is being cleared.
  assign in_ready  = (state_q == ST_MSG) && slot_free && !rst;
  assign accept    = bus.in_valid && in_ready;

  // Lanes above W are never looked at.
  generate
    if (W < 32) begin : g_unused_hi
      logic unused_data_hi;
      assign unused_data_hi = ^bus.data_in[31:W];
    end
  endgenerate

  always_comb begin
    // NOTE: every signal written here gets a default first, so paths that do
    // not touch it still assign it and no latch is inferred.
    state_d     = state_q;
    msg_cnt_d   = msg_cnt_q;
    par_cnt_d   = par_cnt_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    parity_d    = parity_q;
    last_d      = last_q;

    case (state_q)
      ST_MSG: begin
        if (accept) begin
          data_d         = '0;
          data_d[W-1:0]  = bus.data_in[W-1:0];
          out_valid_d    = 1'b1;
          parity_d       = 1'b0;
          last_d         = 1'b0;
          // Per lane: divide by g(x) while shifting the message in; the
          // feedback bit is the incoming bit plus the register's top bit.
          for (int i = 0; i < W; i++) begin
            lfsr_d[i] = {lfsr_q[i][D-2:0], 1'b0} ^
                        ({D{bus.data_in[i] ^ lfsr_q[i][D-1]}} & G);
          end
          if (msg_cnt_q == MSG_LAST) begin
            msg_cnt_d = '0;
            state_d   = ST_PAR;
          end else begin
            msg_cnt_d = msg_cnt_q + 1'b1;
          end
        end else if (bus.out_ready && out_valid_q) begin
          out_valid_d = 1'b0;
        end
      end

      ST_PAR: begin
        if (slot_free) begin
          data_d      = '0;
          out_valid_d = 1'b1;
          parity_d    = 1'b1;
          // Unload the remainder MSB first; shifting in zeros leaves every
          // register clear once the last parity word has gone out.
          for (int i = 0; i < W; i++) begin
            data_d[i] = lfsr_q[i][D-1];
            lfsr_d[i] = {lfsr_q[i][D-2:0], 1'b0};
          end
          if (par_cnt_q == PAR_LAST) begin
            last_d    = 1'b1;
            par_cnt_d = '0;
            state_d   = ST_MSG;
          end else begin
            last_d    = 1'b0;
            par_cnt_d = par_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_MSG;
    endcase
  end

  // NOTE: the lane registers form a small array but are ordinary flops; they
  // are cleared on reset so a codeword cut short never leaks remainder bits
  // into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_MSG;
      msg_cnt_q   <= '0;
      par_cnt_q   <= '0;
      lfsr_q      <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      state_q     <= state_d;
      msg_cnt_q   <= msg_cnt_d;
      par_cnt_q   <= par_cnt_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      parity_q    <= parity_d;
      last_q      <= last_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.data_out   = data_q;
  assign bus.out_parity = parity_q;
  assign bus.out_last   = last_q;

`ifdef CYCENC_CW_COUNT_EN
  // Counts codewords whose final parity word has actually been handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_count <= '0;
    end else if (out_valid_q && bus.out_ready && last_q) begin
      cw_count <= cw_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cyclic_lane_encoder.sv
// ---------------------------------------------------------------------------
// tb_cyclic_lane_encoder
//   Self-checking bench for cyclic_lane_encoder (default parameters).
//   Expected codewords come from polynomial long division per lane; a
//   negedge monitor compares every output handshake against that queue.
//   Define CYCENC_CW_COUNT_EN to also check the codeword counter.
// ---------------------------------------------------------------------------
module tb_cyclic_lane_encoder;

  localparam int unsigned N = 5;
  localparam int unsigned K = 3;
  localparam int unsigned D = N - K;
  localparam int unsigned W = 16;
  localparam logic [31:0] GPOLY     = 32'h7;          // x^2 + x + 1
  localparam logic [31:0] LANE_MASK = 32'h0000_FFFF;

  typedef struct {
    logic [31:0] data;
    logic        parity;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cyclic_lane_encoder_if bus ();

`ifdef CYCENC_CW_COUNT_EN
  logic [15:0] cw_count;
  int          exp_cw = 0;
`endif

  cyclic_lane_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef CYCENC_CW_COUNT_EN
    ,
    .cw_count (cw_count)
`endif
  );

  always #5 clk = ~clk;

  int   checks      = 0;
  int   errors      = 0;
  int   cyc         = 0;
  int   last_hs     = -1;
  bit   contig_mode = 1'b0;
  bit   rand_ready  = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per lane, c(x) = m(x)*x^D mod g(x) by long division.
  // Message word j is the coefficient of x^(K-1-j), i.e. x^(N-1-j) after
  // multiplying by x^D. Parity word p carries remainder degree D-1-p.
  task automatic queue_codeword(input logic [31:0] msgs [K]);
    logic [31:0] par [D];
    logic [31:0] v;
    exp_t        e;
    for (int p = 0; p < D; p++) par[p] = '0;
    for (int lane = 0; lane < W; lane++) begin
      v = '0;
      for (int j = 0; j < K; j++)
        if (msgs[j][lane]) v = v | (32'h1 << (N - 1 - j));
      for (int deg = N - 1; deg >= D; deg--)
        if (v[deg]) v = v ^ (GPOLY << (deg - D));
      for (int p = 0; p < D; p++) par[p][lane] = v[D - 1 - p];
    end
    for (int j = 0; j < K; j++) begin
      e.data = msgs[j] & LANE_MASK; e.parity = 1'b0; e.last = 1'b0;
      exp_q.push_back(e);
    end
    for (int p = 0; p < D; p++) begin
      e.data = par[p]; e.parity = 1'b1; e.last = (p == D - 1);
      exp_q.push_back(e);
    end
  endtask

  // Offers one word and returns at posedge+1 after it was accepted.
  task automatic push_word(input logic [31:0] w);
    int budget = 0;
    bus.data_in  = w;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      budget++;
      if (budget > 60) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_codeword(input logic [31:0] msgs [K], input bit keep_valid, input int max_gap);
    queue_codeword(msgs);
    for (int j = 0; j < K; j++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      push_word(msgs[j]);
    end
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int b = 0;
    while (exp_q.size() != 0 && b < 300) begin
      @(posedge clk);
      b++;
    end
    #1;
    check(tag, exp_q.size(), 32'd0);
  endtask

  always @(posedge clk) cyc++;

  // Random backpressure, applied only when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(3, 0) != 0);
  end

  // Output monitor: inputs only change just after posedge, so the handshake
  // seen here is the one that completes at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
`ifdef CYCENC_CW_COUNT_EN
      exp_cw = 0;
`endif
    end else begin
`ifdef CYCENC_CW_COUNT_EN
      check("cw_count", {16'd0, cw_count}, exp_cw);
`endif
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", bus.data_out, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("data_out",   bus.data_out,   mon_e.data);
          check("out_parity", bus.out_parity, mon_e.parity);
          check("out_last",   bus.out_last,   mon_e.last);
`ifdef CYCENC_CW_COUNT_EN
          if (mon_e.last) exp_cw = (exp_cw + 1) & 32'hFFFF;
`endif
        end
        if (contig_mode && last_hs >= 0) check("contiguous", cyc - last_hs, 32'd1);
        last_hs = cyc;
      end
    end
  end

  initial begin
    logic [31:0] m [K];
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid",  bus.out_valid,  32'd0);
    check("rst_data_out",   bus.data_out,   32'd0);
    check("rst_out_parity", bus.out_parity, 32'd0);
    check("rst_out_last",   bus.out_last,   32'd0);
    check("rst_in_ready",   bus.in_ready,   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed codewords with out_ready held high.
    m = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
    send_codeword(m, 1'b0, 0);
    wait_drain("drain_impulse");
    m = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF};
    send_codeword(m, 1'b0, 0);
    wait_drain("drain_all_ones");
    m = '{32'h0000_0000, 32'h0000_0000, 32'h0000_FFFF};
    send_codeword(m, 1'b0, 0);
    wait_drain("drain_last_ones");
    m = '{32'hA5A5_0001, 32'hA5A5_0000, 32'hA5A5_0002};
    send_codeword(m, 1'b0, 0);
    wait_drain("drain_mixed");

    // Back-to-back codewords: every output word on consecutive cycles.
    contig_mode = 1'b1;
    last_hs     = -1;
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < K; j++) m[j] = $urandom();
      send_codeword(m, (c != 2), 0);
    end
    wait_drain("drain_b2b");
    contig_mode = 1'b0;

    // Backpressure on the first parity word.
    for (int j = 0; j < K; j++) m[j] = $urandom();
    fork
      send_codeword(m, 1'b0, 0);
      begin : bp_ctl
        automatic int b    = 0;
        automatic bit seen = 1'b0;
        while (!seen && b < 40) begin
          @(posedge clk); #2;
          if (bus.out_valid && bus.out_parity && !bus.out_last) seen = 1'b1;
          b++;
        end
        check("bp_found", {31'd0, seen}, 32'd1);
        if (seen) begin
          bus.out_ready = 1'b0;
          for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_data",     bus.data_out,
                  (exp_q.size() != 0) ? exp_q[0].data : 32'hDEAD_BEEF);
            check("bp_valid",    bus.out_valid,  32'd1);
            check("bp_parity",   bus.out_parity, 32'd1);
            check("bp_last",     bus.out_last,   32'd0);
            check("bp_in_ready", bus.in_ready,   32'd0);
          end
          @(posedge clk); #1;
          bus.out_ready = 1'b1;
        end
      end
    join
    wait_drain("drain_bp");

    // Reset after two message words, then a fresh codeword.
    for (int j = 0; j < K; j++) m[j] = $urandom();
    queue_codeword(m);
    push_word(m[0]);
    push_word(m[1]);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid",  bus.out_valid,  32'd0);
    check("midrst_data_out",   bus.data_out,   32'd0);
    check("midrst_out_parity", bus.out_parity, 32'd0);
    check("midrst_out_last",   bus.out_last,   32'd0);
    check("midrst_in_ready",   bus.in_ready,   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < K; j++) m[j] = $urandom();
    send_codeword(m, 1'b0, 0);
    wait_drain("drain_after_rst");

    // Randomized traffic with random gaps and random backpressure.
    rand_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int j = 0; j < K; j++) m[j] = $urandom();
      send_codeword(m, ($urandom_range(1, 0) == 1) && (c != 19), 2);
    end
    bus.in_valid  = 1'b0;
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("drain_random");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cyclic_lane_encoder.md
Name: cyclic_lane_encoder

Overview:
- Transmit-side systematic cyclic encoder for the 16-lane bit-serial code path. Each bit lane of data_in carries one message bit per word.
- After K message words, the block appends D = N-K parity words. Each parity bit is the per-lane remainder of m(x)·x^D mod g(x).
- It is the encoder counterpart of the receive-side fixed-depth (N-K) data delay/syndrome path. Its output feeds the PCI link data word stream.

Parameters:
- N, 5, codeword length in words (bits per lane)
- K, 3, message length in words; D = N-K is a localparam and must be >= 2
- G, 2'b11, low D coefficients of g(x) (implicit x^D term); default g(x)=x^2+x+1
- W, 16, active lanes; data bits [W-1:0] are used

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  message word valid
- in_ready  out  1  block accepts message word this cycle
- data_in  in  32  message word; bits [31:W] are ignored
- out_valid  out  1  data_out holds a codeword word
- out_ready  in  1  downstream accepts word
- data_out  out  32  codeword word; bits [31:W] always 0
- out_parity  out  1  current output word is a parity word
- out_last  out  1  current output word is the final word (D-th parity) of the codeword

Behaviour:
- Reset (async, rst=1): state=MSG, msg_cnt=0, par_cnt=0, all lane LFSRs=0. Outputs: out_valid=0, data_out=0, out_parity=0, out_last=0, in_ready=0 while rst is asserted.
- Output register: single stage. slot_free = !out_valid || out_ready.
- in_ready = (state==MSG) && slot_free, combinational.
- State MSG, accept (in_valid && in_ready):
  - data_out[W-1:0] <= data_in[W-1:0]; out_valid<=1; out_parity<=0; out_last<=0.
  - Per lane i: fb = data_in[i] ^ lfsr_i[D-1]; lfsr_i <= {lfsr_i[D-2:0],1'b0} ^ (fb ? G : 0).
  - msg_cnt++. On the K-th accept, msg_cnt<=0 and state->PAR.
- State MSG, no accept: if out_ready && out_valid, out_valid<=0. Otherwise hold.
- State PAR, when slot_free:
  - data_out[i] <= lfsr_i[D-1] (MSB first); lfsr_i <= {lfsr_i[D-2:0],1'b0}; out_valid<=1; out_parity<=1.
  - par_cnt++. On the D-th parity word, out_last<=1, par_cnt<=0, state->MSG. LFSRs are zero by construction.
- Latency: a message word appears on data_out 1 cycle after acceptance. The first parity word can be loaded in the cycle after the K-th accept. With out_ready held high, a codeword takes N consecutive cycles.
- Throughput: one word per cycle with out_ready=1. in_ready=0 for exactly D cycles per codeword.
- Backpressure: while out_valid && !out_ready, data_out, out_parity and out_last are stable, and no state or LFSR update occurs.
- First message bit in is the highest-degree coefficient, x^(K-1).
- Lanes are fully independent. Upper input bits never affect any output.
- Reset mid-codeword: partial codeword is discarded. The next accepted word after reset is message word 0.

Optional Feature:
- Macro: CYCENC_CW_COUNT_EN.
- Defined: adds output port cw_count (out, 16). It resets to 0, increments on each handshake (out_valid && out_ready) of an out_last word, and wraps 16'hFFFF->0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, out_ready=1; message words 0x0001, 0x0000, 0x0000 -> data_out 0x0001, 0x0000, 0x0000, then 0x0001 (parity), 0x0000 (parity, out_last=1). Remainder = x.
- Message 0xFFFF x3 -> parity words 0x0000, 0x0000. Message 0x0000, 0x0000, 0xFFFF -> parity 0xFFFF, 0xFFFF.
- Mixed lanes: lane0 message 1,0,0; lane1 message 0,0,1; data_in[31:16]=0xA5A5 -> parity words 0x0003 then 0x0002; data_out[31:16]=0 throughout.
- Backpressure: hold out_ready=0 for 4 cycles during parity word 1 -> data_out, out_parity=1 and out_last=0 are stable; in_ready=0 throughout; sequence resumes unchanged.
- Assert rst after 2 message words -> outputs go to 0 immediately. The next 3 accepted words form a fresh codeword with correct parity.
- With CYCENC_CW_COUNT_EN: 3 back-to-back codewords -> cw_count = 1, 2, 3, each updating the cycle after its out_last handshake.
